// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - request/grant and ROM-side signal bundle for sprite_rom_arbiter
interface sprite_rom_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 18,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               addr_err;

    modport slave (
        input  req, addr, rom_data,
        output gnt, rom_addr, rvalid, rdata, addr_err
    );

    modport master (
        output req, addr, rom_data,
        input  gnt, rom_addr, rvalid, rdata, addr_err
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin arbiter sharing one sprite ROM read port
// Grant is combinational; returned data is tagged back after a fixed READ_LAT+2 cycles.
module sprite_rom_arbiter #(
    parameter int NREQ      = 4,
    parameter int AW        = 18,
    parameter int DW        = 8,
    parameter int READ_LAT  = 1,
    parameter int ROM_DEPTH = 200000
) (
    input  logic                Clk50,
    input  logic                Reset_n,
    sprite_rom_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] ROM_DEPTH_W = (AW+1)'(ROM_DEPTH);

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] id;
    } tag_t;

    logic [IW-1:0]   last_q, last_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic            addr_err_q, addr_err_d;
    tag_t            tag_q [READ_LAT+1];
    tag_t            tag_d [READ_LAT+1];

    logic            found;
    logic [IW-1:0]   gnt_id;
    logic [AW-1:0]   sel_addr;
    logic            illegal;

    // Search starts just past the last winner so every requester waits at most NREQ-1 cycles.
    always_comb begin
        found  = 1'b0;
        gnt_id = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req[(int'(last_q) + k) % NREQ]) begin
                found  = 1'b1;
                gnt_id = IW'((int'(last_q) + k) % NREQ);
            end
        end
        sel_addr = bus.addr[int'(gnt_id)*AW +: AW];
        illegal  = ({1'b0, sel_addr} >= ROM_DEPTH_W);
        bus.gnt  = found ? (NREQ'(1) << gnt_id) : '0;
    end

    always_comb begin
        last_d     = last_q;
        rom_addr_d = rom_addr_q;
        addr_err_d = 1'b0;
        tag_d[0]   = '0;
        if (found) begin
            last_d     = gnt_id;
            rom_addr_d = illegal ? '0 : sel_addr;
            addr_err_d = illegal;
            tag_d[0]   = '{valid: 1'b1, id: gnt_id};
        end
        for (int s = 1; s <= READ_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        // The oldest tag lines up with the cycle rom_data is valid for it.
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_q[READ_LAT].valid) begin
            rvalid_d = NREQ'(1) << tag_q[READ_LAT].id;
            rdata_d  = bus.rom_data;
        end
    end

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            last_q     <= IW'(NREQ - 1);
            rom_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            addr_err_q <= 1'b0;
            for (int s = 0; s <= READ_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            last_q     <= last_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
            for (int s = 0; s <= READ_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.addr_err = addr_err_q;
endmodule
